// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer state encoding and default geometry, shared by the
// scanout arbiter and the VGA timing generator.
package fb_pkg;

    typedef enum logic [1:0] {
        FB_IDLE     = 2'd0,
        FB_PREFETCH = 2'd1,
        FB_DRAIN    = 2'd2
    } fb_state_t;

    localparam int FB_DEF_WIDTH          = 200;
    localparam int FB_DEF_HEIGHT         = 150;
    localparam int FB_DEF_ADDR_W         = 15;
    localparam int FB_DEF_DATA_W         = 12;
    localparam int FB_DEF_WR_SLOT_PERIOD = 8;
    localparam int FB_LINE_NUM_W         = 10;

    // Word address of the first pixel of a line, before truncation to ADDR_W.
    function automatic logic [31:0] fb_line_base(input logic [FB_LINE_NUM_W-1:0] line,
                                                 input int unsigned width);
        return 32'(line) * 32'(width);
    endfunction

endpackage

// File: rtl/fb_slot_counter.sv
// fb_slot_counter: counts prefetch reads since the last writer-slot
// opportunity and flags when the next cycle may be handed to the writer.
// A period of 0 never opens a slot.
module fb_slot_counter
    import fb_pkg::*;
#(
    parameter int WR_SLOT_PERIOD = FB_DEF_WR_SLOT_PERIOD
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_grant,
    output logic o_slot_due
);
    localparam int CNT_W = (WR_SLOT_PERIOD < 1) ? 1 : $clog2(WR_SLOT_PERIOD + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_slot_due = (WR_SLOT_PERIOD > 0) && (r_cnt == CNT_W'(WR_SLOT_PERIOD));

    // Read run length; a declined opportunity still reads, so that read starts the next run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_active) begin
            if (i_grant)
                r_cnt <= '0;
            else if (o_slot_due)
                r_cnt <= CNT_W'(1);
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: shares a single-port framebuffer RAM between the
// line-buffer prefetch (one line per line_req) and a pixel writer.
// Optional feature macro: FB_ARB_UNDERRUN_CNT_EN adds a saturating
// underrun event counter; without it underrun_count is tied to 0.
module fb_scanout_arbiter
    import fb_pkg::*;
#(
    parameter int FB_WIDTH       = FB_DEF_WIDTH,
    parameter int FB_HEIGHT      = FB_DEF_HEIGHT,
    parameter int ADDR_W         = FB_DEF_ADDR_W,
    parameter int DATA_W         = FB_DEF_DATA_W,
    parameter int WR_SLOT_PERIOD = FB_DEF_WR_SLOT_PERIOD
)(
    input  logic                        VGA_CLK,
    input  logic                        RESET,
    input  logic                        line_req,
    input  logic [FB_LINE_NUM_W-1:0]    line_num,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        lb_we,
    output logic [$clog2(FB_WIDTH)-1:0] lb_addr,
    output logic [DATA_W-1:0]           lb_wdata,
    output logic                        busy,
    output logic                        prefetch_done,
    output logic                        underrun,
    input  logic                        underrun_clr,
    output logic [15:0]                 underrun_count
);
    localparam int          LB_AW    = $clog2(FB_WIDTH);
    localparam int unsigned FB_WORDS = FB_WIDTH * FB_HEIGHT;
    localparam logic [LB_AW-1:0] LB_LAST = LB_AW'(FB_WIDTH - 1);

    fb_state_t         r_state, w_state_nx;
    logic [ADDR_W-1:0] r_base;
    logic [LB_AW-1:0]  r_rd_idx;
    logic              r_lb_vld_p1;
    logic [LB_AW-1:0]  r_lb_addr_p1;
    logic              r_underrun;

    logic w_idle, w_prefetch, w_drain;
    logic w_accept, w_overrun, w_slot_due, w_slot, w_rd;

    // Everything combinational is forced quiet while RESET is high.
    assign w_idle     = !RESET && (r_state == FB_IDLE);
    assign w_prefetch = !RESET && (r_state == FB_PREFETCH);
    assign w_drain    = !RESET && (r_state == FB_DRAIN);
    assign w_accept   = w_idle && line_req && (32'(line_num) < 32'(FB_HEIGHT));
    assign w_overrun  = !RESET && line_req && (r_state != FB_IDLE);
    assign w_slot     = w_prefetch && w_slot_due && wr_valid;
    assign w_rd       = w_prefetch && !w_slot;

    fb_slot_counter #(
        .WR_SLOT_PERIOD (WR_SLOT_PERIOD)
    ) u_slot (
        .i_clk      (VGA_CLK),
        .i_rst      (RESET),
        .i_clear    (w_accept),
        .i_active   (w_prefetch),
        .i_grant    (w_slot),
        .o_slot_due (w_slot_due)
    );

    // State register.
    always_ff @(posedge VGA_CLK) begin
        if (RESET)
            r_state <= FB_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Next state: prefetch ends on the last read, DRAIN lasts exactly one cycle.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            FB_IDLE:     if (w_accept) w_state_nx = FB_PREFETCH;
            FB_PREFETCH: if (w_rd && (r_rd_idx == LB_LAST)) w_state_nx = FB_DRAIN;
            FB_DRAIN:    w_state_nx = FB_IDLE;
            default:     w_state_nx = FB_IDLE;
        endcase
    end

    // Read pointer and the one-cycle line-buffer write pipeline matching RAM latency.
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            r_base       <= '0;
            r_rd_idx     <= '0;
            r_lb_vld_p1  <= 1'b0;
            r_lb_addr_p1 <= '0;
        end else begin
            r_lb_vld_p1  <= w_rd;
            r_lb_addr_p1 <= r_rd_idx;
            if (w_accept) begin
                r_base   <= ADDR_W'(fb_line_base(line_num, FB_WIDTH));
                r_rd_idx <= '0;
            end else if (w_rd) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    // Sticky underrun: a new request while busy wins over a same-cycle clear.
    always_ff @(posedge VGA_CLK) begin
        if (RESET)
            r_underrun <= 1'b0;
        else if (w_overrun)
            r_underrun <= 1'b1;
        else if (underrun_clr)
            r_underrun <= 1'b0;
    end

`ifdef FB_ARB_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Saturating underrun event count, cleared only by RESET.
    always_ff @(posedge VGA_CLK) begin
        if (RESET)
            r_underrun_cnt <= '0;
        else if (w_overrun && (r_underrun_cnt != 16'hFFFF))
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end

    assign underrun_count = r_underrun_cnt;
`else
    assign underrun_count = '0;
`endif

    // The RAM port carries the read address only on read cycles; otherwise the writer owns it.
    assign wr_ready      = w_idle || w_drain || w_slot;
    assign mem_we        = wr_valid && wr_ready && (32'(wr_addr) < FB_WORDS);
    assign mem_addr      = w_rd ? (r_base + ADDR_W'(r_rd_idx)) : wr_addr;
    assign mem_wdata     = wr_data;
    assign lb_we         = r_lb_vld_p1 && !RESET;
    assign lb_addr       = r_lb_addr_p1;
    assign lb_wdata      = mem_rdata;
    assign prefetch_done = lb_we && (r_lb_addr_p1 == LB_LAST);
    assign busy          = !RESET && (r_state != FB_IDLE);
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Testbench for fb_scanout_arbiter: behavioural RAM, per-cycle reference
// model, directed scenarios with literal expectations, then random traffic.
module tb_fb_scanout_arbiter;
    localparam int W   = 200;
    localparam int H   = 150;
    localparam int AW  = 15;
    localparam int DW  = 12;
    localparam int P   = 8;
    localparam int LBW = 8;
`ifdef FB_ARB_UNDERRUN_CNT_EN
    localparam int EXP_UCNT_ONE = 1;
`else
    localparam int EXP_UCNT_ONE = 0;
`endif

    logic           VGA_CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           line_req = 1'b0;
    logic [9:0]     line_num = '0;
    logic           wr_valid = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_ready;
    logic [AW-1:0]  mem_addr;
    logic           mem_we;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata = '0;
    logic           lb_we;
    logic [LBW-1:0] lb_addr;
    logic [DW-1:0]  lb_wdata;
    logic           busy;
    logic           prefetch_done;
    logic           underrun;
    logic           underrun_clr = 1'b0;
    logic [15:0]    underrun_count;

    fb_scanout_arbiter #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .WR_SLOT_PERIOD(P)
    ) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .line_req(line_req), .line_num(line_num),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .busy(busy),
        .prefetch_done(prefetch_done), .underrun(underrun), .underrun_clr(underrun_clr),
        .underrun_count(underrun_count)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    // Single-port RAM, one-cycle read latency
    logic [DW-1:0] ram [0:32767];
    always @(posedge VGA_CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int m_phase = 0;   // 0 idle, 1 fetching a line, 2 final line-buffer write
    int m_next  = 0;   // reads issued so far in this line
    int m_base  = 0;
    int m_run   = 0;   // reads since last slot opportunity
    int m_lba   = 0;
    int m_lbd   = 0;
    int m_ucnt  = 0;
    bit m_lbw   = 0;
    bit m_under = 0;

    // Observations for directed literal checks
    int cyc = 0, t_acc = -1, t_done = -1, n_done = 0, n_lbwe = 0, n_we_busy = 0, first_addr = -1;
    bit acc_we = 0;

    always @(negedge VGA_CLK) begin
        bit slot, rd, rdy, we;
        int raddr, exp_ucnt;
        cyc++;
`ifdef FB_ARB_UNDERRUN_CNT_EN
        exp_ucnt = m_ucnt;
`else
        exp_ucnt = 0;
`endif
        if (RESET) begin
            check("rst_busy", busy, 0);
            check("rst_wr_ready", wr_ready, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_lb_we", lb_we, 0);
            check("rst_done", prefetch_done, 0);
            check("rst_underrun_hold", underrun, m_under);
            check("rst_ucnt_hold", underrun_count, exp_ucnt);
            m_phase = 0; m_lbw = 0; m_under = 0; m_run = 0; m_next = 0; m_ucnt = 0;
        end else begin
            slot  = (m_phase == 1) && (P > 0) && (m_run == P) && wr_valid;
            rd    = (m_phase == 1) && !slot;
            rdy   = (m_phase != 1) || slot;
            we    = wr_valid && rdy && (int'(wr_addr) < W * H);
            raddr = (m_base + m_next) % 32768;
            check("busy", busy, m_phase != 0);
            check("wr_ready", wr_ready, rdy);
            check("mem_we", mem_we, we);
            check("lb_we", lb_we, m_lbw);
            check("prefetch_done", prefetch_done, m_lbw && (m_lba == W - 1));
            check("underrun", underrun, m_under);
            check("underrun_count", underrun_count, exp_ucnt);
            if (rd) check("rd_addr", mem_addr, raddr);
            if (we) begin
                check("wr_addr_out", mem_addr, wr_addr);
                check("wr_data_out", mem_wdata, wr_data);
            end
            if (m_lbw) begin
                check("lb_addr", lb_addr, m_lba);
                check("lb_wdata", lb_wdata, m_lbd);
            end
            if (prefetch_done) begin n_done++; t_done = cyc; end
            if (lb_we) n_lbwe++;
            if (mem_we && m_phase != 0) n_we_busy++;
            if (rd && m_next == 0) first_addr = mem_addr;
            // advance the model by one clock
            if (line_req && m_phase != 0) begin
                m_under = 1;
                if (m_ucnt < 65535) m_ucnt++;
            end else if (underrun_clr) begin
                m_under = 0;
            end
            m_lbw = rd;
            m_lba = m_next;
            if (rd) m_lbd = ram[raddr];
            case (m_phase)
                0: if (line_req && line_num < H) begin
                    m_phase = 1; m_base = (line_num * W) % 32768; m_next = 0; m_run = 0;
                    t_acc = cyc; acc_we = mem_we;
                end
                1: if (slot) m_run = 0;
                   else begin
                       m_run = (P > 0 && m_run == P) ? 1 : m_run + 1;
                       m_next++;
                       if (m_next == W) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0 = n_done;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (n_done > d0) seen = 1;
        end
        check("wait_done_timeout", seen, 1);
    endtask

    initial begin
        int l0, d0, w0;
        for (int i = 0; i < 32768; i++) ram[i] = DW'($urandom);

        // reset
        step(); step();
        check("rst_wr_ready_lit", wr_ready, 0);
        check("rst_busy_lit", busy, 0);
        RESET = 0;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_underrun", underrun, 0);
        check("post_rst_ucnt", underrun_count, 0);
        check("post_rst_wr_ready", wr_ready, 1);

        // line 3, no writer
        l0 = n_lbwe;
        line_num = 10'd3; line_req = 1; step(); line_req = 0;
        wait_done(400);
        check("s1_first_addr", first_addr, 600);
        check("s1_latency", t_done - t_acc, 201);
        check("s1_lb_count", n_lbwe - l0, 200);

        // line 0 with writer always valid; write granted on the request cycle too
        wr_addr = 15'd20000; wr_data = 12'h5A5; wr_valid = 1;
        w0 = n_we_busy;
        line_num = 10'd0; line_req = 1; step(); line_req = 0;
        wait_done(400);
        wr_valid = 0;
        check("s2_req_cycle_write", acc_we, 1);
        check("s2_first_addr", first_addr, 0);
        check("s2_busy_writes", n_we_busy - w0, 25);
        check("s2_latency", t_done - t_acc, 225);

        // second request 50 cycles into a prefetch
        line_num = 10'd5; line_req = 1; step(); line_req = 0;
        repeat (49) step();
        line_num = 10'd7; line_req = 1; step(); line_req = 0;
        check("s3_underrun_set", underrun, 1);
        wait_done(400);
        check("s3_first_addr", first_addr, 1000);
        check("s3_latency", t_done - t_acc, 201);
        underrun_clr = 1; step(); underrun_clr = 0;
        check("s3_underrun_clr", underrun, 0);
        check("s3_ucnt", underrun_count, EXP_UCNT_ONE);

        // out-of-range line and out-of-range write
        l0 = n_lbwe;
        line_num = 10'd150; line_req = 1; step(); line_req = 0;
        repeat (5) step();
        check("s4_busy", busy, 0);
        check("s4_no_lb", n_lbwe - l0, 0);
        wr_valid = 1; wr_addr = 15'd30000; #2;
        check("s4_wr_ready", wr_ready, 1);
        check("s4_mem_we", mem_we, 0);
        step(); wr_valid = 0;

        // reset in the middle of a prefetch
        line_num = 10'd2; line_req = 1; step(); line_req = 0;
        d0 = n_done;
        repeat (100) step();
        RESET = 1; step(); RESET = 0; #2;
        check("s5_busy", busy, 0);
        check("s5_lb_we", lb_we, 0);
        check("s5_wr_ready", wr_ready, 1);
        repeat (250) step();
        check("s5_no_done", n_done - d0, 0);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            line_req     = ($urandom_range(0, 79) == 0);
            line_num     = 10'($urandom_range(0, 170));
            wr_valid     = $urandom_range(0, 1) == 1;
            wr_addr      = AW'($urandom_range(0, 32767));
            wr_data      = DW'($urandom);
            underrun_clr = ($urandom_range(0, 39) == 0);
            RESET        = ($urandom_range(0, 2999) == 0);
            step();
        end
        line_req = 0; wr_valid = 0; underrun_clr = 0; RESET = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_scanout_arbiter.md
FB_SCANOUT_ARBITER -- requirements
Module: fb_scanout_arbiter

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 200, pixels (words) per framebuffer line.
REQ-002 SHALL have parameter FB_HEIGHT, default 150, lines per framebuffer.
REQ-003 SHALL have parameter ADDR_W, default 15, framebuffer word-address width.
REQ-004 SHALL have parameter DATA_W, default 12, pixel width (4R/4G/4B).
REQ-005 SHALL have parameter WR_SLOT_PERIOD, default 8, prefetch reads between writer slots; 0 = writer locked out during prefetch.
REQ-006 SHALL have port VGA_CLK  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port RESET  in  1  synchronous active-high reset.
REQ-008 SHALL have port line_req  in  1  one-cycle pulse from timing generator: prefetch line line_num.
REQ-009 SHALL have port line_num  in  10  framebuffer line to prefetch, sampled with line_req.
REQ-010 SHALL have ports wr_valid in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ready out 1: pixel-writer valid/ready port.
REQ-011 SHALL have ports mem_addr out ADDR_W, mem_we out 1, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port framebuffer RAM, read latency 1 cycle.
REQ-012 SHALL have ports lb_we out 1, lb_addr out $clog2(FB_WIDTH), lb_wdata out DATA_W: line-buffer write port.
REQ-013 SHALL have ports busy out 1, prefetch_done out 1 (pulse), underrun out 1 (sticky), underrun_clr in 1, underrun_count out 16.

Function
REQ-014 SHALL implement states IDLE, PREFETCH, DRAIN; IDLE->PREFETCH on line_req with line_num<FB_HEIGHT; PREFETCH->DRAIN after issuing read FB_WIDTH-1; DRAIN->IDLE unconditionally after one cycle.
REQ-015 SHALL ignore line_req with line_num>=FB_HEIGHT in IDLE: no reads, no lb_we, no underrun.
REQ-016 SHALL compute line base = line_num*FB_WIDTH truncated to ADDR_W, registered on accepting line_req.
REQ-017 SHALL, line_req accepted at cycle t, drive mem_addr=base at t+1, incrementing by 1 per read cycle.
REQ-018 SHALL assert lb_we one cycle after each read, lb_wdata=mem_rdata, lb_addr=0..FB_WIDTH-1 in order.
REQ-019 SHALL pulse prefetch_done in the cycle of the lb_we with lb_addr=FB_WIDTH-1 (the DRAIN cycle).
REQ-020 SHALL assert busy in PREFETCH and DRAIN only.
REQ-021 SHALL assert wr_ready in IDLE (including the cycle line_req arrives) and in DRAIN, and in PREFETCH only on a writer slot.
REQ-022 SHALL, in PREFETCH with WR_SLOT_PERIOD>0, grant a writer slot after every WR_SLOT_PERIOD consecutive reads if wr_valid=1; slot cycle issues no read, read address holds; slot skipped (no stall) if wr_valid=0.
REQ-023 SHALL drive mem_we=wr_valid&wr_ready&(wr_addr<FB_WIDTH*FB_HEIGHT); out-of-range writes are accepted and dropped; mem_wdata=wr_data.
REQ-024 SHALL, on line_req in PREFETCH or DRAIN, ignore it, continue current prefetch, set underrun=1.
REQ-025 SHALL clear underrun on underrun_clr; simultaneous set and clear leaves underrun=1.

Reset
REQ-026 SHALL, on RESET, enter IDLE and zero read/slot counters, base, underrun, underrun_count, lb_we, mem_we, prefetch_done, busy, wr_ready held 0 during reset cycle.
REQ-027 SHALL, on RESET mid-prefetch, suppress the lb_we for any read in flight; no prefetch_done.

Configuration
REQ-028 SHALL, with FB_ARB_UNDERRUN_CNT_EN defined, increment underrun_count (saturating at 16'hFFFF) on each REQ-024 event, clear on RESET only.
REQ-029 SHALL, without FB_ARB_UNDERRUN_CNT_EN, tie underrun_count to 0 and synthesise no counter; sticky underrun unaffected.

Structure
REQ-030 SHALL place state encoding (IDLE/PREFETCH/DRAIN) and default geometry constants in shared package fb_pkg, reused by the VGA timing generator.
REQ-031 SHALL contain one sub-module, fb_slot_counter, generating writer-slot timing from WR_SLOT_PERIOD.

Verification
REQ-032 SHALL cover: line_req, line_num=3, wr_valid=0 -> mem_addr 600..799 on 200 cycles, lb_we 200 cycles lb_addr 0..199, prefetch_done 201 cycles after line_req.
REQ-033 SHALL cover: wr_valid=1 held during prefetch line 0, WR_SLOT_PERIOD=8 -> 25 writes (24 in PREFETCH, 1 in DRAIN), read address frozen on each slot, prefetch_done 225 cycles after line_req.
REQ-034 SHALL cover: line_req at cycle 50 of prefetch -> underrun=1, current prefetch completes unchanged; underrun_clr -> underrun=0; count=1 with macro, 0 without.
REQ-035 SHALL cover: line_req line_num=150 -> no mem_addr sweep, busy=0; wr_addr=30000 write -> wr_ready=1, mem_we=0.
REQ-036 SHALL cover: RESET at read 100 of prefetch -> next cycle IDLE, lb_we=0, busy=0, no prefetch_done, wr_ready=1 after reset released.
REQ-037 SHALL cover: line_req and wr_valid same IDLE cycle -> write granted that cycle, prefetch starts next cycle.
